piso_serializer: RTL
====================

# piso_serializer

Parallel-in/serial-out stage feeding the serial sequence-detector FSMs (`in` input). It accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per enabled clock. It provides a bit-valid qualifier and an end-of-frame pulse. It is the upstream source of the serial bit stream that the 11011 detectors consume.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥2).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  bit-rate strobe; shifting advances only on cycles with en=1.
- din  input  WIDTH  parallel word.
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept a word this cycle (combinational).
- sout  output  1  serial bit; drives the detector `in`.
- sout_valid  output  1  sout carries a frame bit.
- frame_done  output  1  high on the final bit of a frame.
- busy  output  1  a frame is in progress.

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with SER_PARITY_EN).
- Handshake: a word transfers on a rising edge with din_valid=1 and din_ready=1. din_valid is ignored when din_ready=0, and the word must be held by the source.
- din_ready = !rst & (state==IDLE | (on final bit of frame & en)).
- IDLE: sout=0, sout_valid=0, busy=0. On transfer, load the shift register with din, set the bit counter to WIDTH-1, and move to SHIFT.
- SHIFT: sout = shreg[WIDTH-1], sout_valid=1, busy=1.
  - en=1 with count>0: shift left by 1 and decrement the count.
  - en=1 with count==0 (last data bit): go to PARITY if enabled. Otherwise, on a simultaneous transfer, reload and stay in SHIFT; else go to IDLE.
  - en=0: all state held, and sout holds its bit.
- PARITY: sout = even parity of the word (XOR of all WIDTH bits), sout_valid=1. With en=1, reload on a simultaneous transfer (next state SHIFT); else go to IDLE. With en=0, hold.
- frame_done = sout_valid & on final bit of frame (last data bit without parity, parity bit with it). It is independent of en.
- Bit counter width is $clog2(WIDTH); no wrap: the count never decrements below 0.
- Reset mid-frame: next cycle state=IDLE and sout=sout_valid=busy=frame_done=0. Any partial frame is discarded with no completion.

## Timing
- Reset values: sout=0, sout_valid=0, busy=0, frame_done=0, din_ready=0 while rst=1, counter=0, shreg=0.
- Latency: the word accepted at edge N presents its MSB from edge N (registered) through the next enabled edge.
- With en held 1: WIDTH (+1 with parity) cycles per frame.
- Back-to-back transfers with en=1 give zero gap cycles between frames.
- sout, sout_valid, busy and frame_done are registered/state-decoded: no combinational path from din/din_valid.
- en is sampled each edge. en=0 stretches the current bit indefinitely.

## Configuration
- SER_PARITY_EN defined: one even-parity bit is appended after each word (frame = WIDTH+1 bits), and the PARITY state is present.
- SER_PARITY_EN undefined: frame = WIDTH bits, the PARITY state is absent, and din_ready asserts on the last data bit.

## Structure
- Package `ser_pkg`:
  - state enum typedef (IDLE, SHIFT, PARITY);
  - localparam default WIDTH;
  - function for the counter width.
- One sub-module `ser_bit_counter`: loadable down-counter with enable, exposing `zero`. The FSM and shift register live in the top.

## Test plan
- Single word, WIDTH=8, din=8'hDB, en=1 -> sout = 1,1,0,1,1,0,1,1 on 8 consecutive cycles with sout_valid=1. frame_done is high on the 8th bit only. With SER_PARITY_EN, a 9th bit 0 follows (six ones) with frame_done on it. A downstream 11011 detector sees two overlapping 11011 patterns.
- Back-to-back: din_valid held with 8'hDB then 8'h1B -> 16 (18 with parity) contiguous valid bits with no gap; din_ready is high only on the final bit of the first frame.
- Stall: en=0 for 3 cycles after bit 3 of 8'hA5 -> sout holds 0 for 4 cycles, busy=1, and the remaining bits 0,1,0,1 follow correctly.
- Busy rejection: din_valid=1 with din=8'hFF during bit 2 of a frame -> not accepted. The current frame completes unchanged and 8'hFF is accepted only when din_ready=1.
- Reset mid-frame: rst=1 at bit 4 -> next cycle all outputs 0 and din_ready=0. After rst drops, din_ready=1 and a new word 8'h3C serializes from its MSB.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    localparam int SER_DEFAULT_WIDTH = 8;

    // Width of the bit counter that indexes a WIDTH-bit word (at least one bit).
    function automatic int ser_cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter that saturates at zero; zero_o flags the last data bit.
module ser_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins over decrement, and the count never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/piso_serializer.sv
// Valid/ready word intake, MSB-first serial output with bit-valid and end-of-frame.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int            CW       = ser_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             last_bit;
    logic             xfer;
`ifdef SER_PARITY_EN
    logic             parity_q;
    logic             parity_d;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    ser_bit_counter #(
        .CW (CW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LAST_IDX),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

`ifdef SER_PARITY_EN
    assign last_bit = (state_q == PARITY);
`else
    assign last_bit = (state_q == SHIFT) && cnt_zero;
`endif

    // Ready in IDLE, or on the final bit when it is being consumed this edge.
    assign din_ready = !rst && ((state_q == IDLE) || (last_bit && en));
    assign xfer      = din_valid && din_ready;

    // Next-state, shift register and counter control.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef SER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d  = SHIFT;
                    shreg_d  = din;
                    cnt_load = 1'b1;
`ifdef SER_PARITY_EN
                    parity_d = even_parity(din);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (!en) begin
                    state_d = SHIFT;
                end else if (!cnt_zero) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_dec = 1'b1;
                end else begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    if (xfer) begin
                        state_d  = SHIFT;
                        shreg_d  = din;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (!en) begin
                    state_d = PARITY;
                end else if (xfer) begin
                    state_d  = SHIFT;
                    shreg_d  = din;
                    cnt_load = 1'b1;
                    parity_d = even_parity(din);
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= {WIDTH{1'b0}};
`ifdef SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
`ifdef SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Serial bit decoded from registered state only, so din never reaches sout.
    always_comb begin
        sout = 1'b0;
        case (state_q)
            SHIFT:   sout = shreg_q[WIDTH-1];
`ifdef SER_PARITY_EN
            PARITY:  sout = parity_q;
`endif
            default: sout = 1'b0;
        endcase
    end

    assign sout_valid = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign frame_done = sout_valid && last_bit;

endmodule
